// File: rtl/contador_campos_rep_if.sv
// Bundle of edit-path signals between the RTC set-up logic and the field counter.
// master drives buttons, load and limits; slave returns selection, field values and change strobe.
interface contador_campos_rep_if #(
  parameter int NCH = 3,
  parameter int W   = 7
);
  localparam int SW = $clog2(NCH);

  logic            en;
  logic            W_R;
  logic            up;
  logic            down;
  logic            left;
  logic            right;
  logic            ld;
  logic [NCH*W-1:0] ld_data;
  logic [NCH*W-1:0] lim_min;
  logic [NCH*W-1:0] lim_max;
  logic [SW-1:0]   sel;
  logic [NCH*W-1:0] cnt;
  logic            chg;

  modport master (
    output en, W_R, up, down, left, right, ld, ld_data, lim_min, lim_max,
    input  sel, cnt, chg
  );

  modport slave (
    input  en, W_R, up, down, left, right, ld, ld_data, lim_min, lim_max,
    output sel, cnt, chg
  );
endinterface

// File: rtl/contador_campos_rep.sv
// Multi-field up/down editing counter with field select, auto-repeat and parallel load.
// Button levels are edge-detected here; all inputs are sampled, nothing is a valid/ready handshake.
module contador_campos_rep #(
  parameter int NCH      = 3,
  parameter int W        = 7,
  parameter int HOLD_CYC = 50000000,
  parameter int REP_CYC  = 10000000
) (
  input  logic                      clk,
  input  logic                      rst,
  contador_campos_rep_if.slave      bus,
  output logic [1:0]                state_o
);
  localparam int SW   = $clog2(NCH);
  localparam int TMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             dir_q, dir_d;
  logic [NCH*W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             chg_q;
  logic [3:0]       prev_q;

  logic [3:0]   btn;
  logic [3:0]   press;
  logic         sel_chg;
  logic         do_step;
  logic         step_up;
  logic         held;
  logic         other;
  logic [W-1:0] cur, mn, mx, up_val, dn_val;

  assign btn   = {bus.up, bus.down, bus.left, bus.right};
  assign press = btn & ~prev_q;

  // Selection; a simultaneous left+right press cancels out.
  always_comb begin
    sel_d   = sel_q;
    sel_chg = 1'b0;
    if (press[0] && !press[1]) begin
      sel_chg = 1'b1;
      sel_d   = (sel_q == SW'(NCH - 1)) ? '0 : sel_q + 1'b1;
    end else if (press[1] && !press[0]) begin
      sel_chg = 1'b1;
      sel_d   = (sel_q == '0) ? SW'(NCH - 1) : sel_q - 1'b1;
    end
  end

  always_comb begin
    cur    = cnt_q[int'(sel_q) * W +: W];
    mn     = bus.lim_min[int'(sel_q) * W +: W];
    mx     = bus.lim_max[int'(sel_q) * W +: W];
    up_val = (cur >= mx) ? mn : cur + 1'b1;
    dn_val = (cur <= mn || cur > mx) ? mx : cur - 1'b1;
  end

  // Step sequencer: a selection change always drops back to IDLE without stepping.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    do_step = 1'b0;
    step_up = dir_q;
    held    = dir_q ? bus.up : bus.down;
    other   = dir_q ? bus.down : bus.up;
    if (sel_chg) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press[3] && !bus.down) begin
            do_step = 1'b1;
            step_up = 1'b1;
            dir_d   = 1'b1;
            timer_d = '0;
            state_d = HOLD;
          end else if (press[2] && !bus.up) begin
            do_step = 1'b1;
            step_up = 1'b0;
            dir_d   = 1'b0;
            timer_d = '0;
            state_d = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (held && !other) begin
            if (timer_q == ((state_q == HOLD) ? TW'(HOLD_CYC - 1) : TW'(REP_CYC - 1))) begin
              do_step = 1'b1;
              timer_d = '0;
              state_d = REPEAT;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (do_step) cnt_d[int'(sel_q) * W +: W] = step_up ? up_val : dn_val;
  end

  // Edge-detect history tracks the buttons every cycle, even across reset, load and freeze.
  always_ff @(posedge clk) begin
    prev_q <= btn;
    if (!rst) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      chg_q   <= 1'b0;
      state_q <= IDLE;
      timer_q <= '0;
      dir_q   <= 1'b0;
    end else if (bus.ld) begin
      cnt_q   <= bus.ld_data;
      chg_q   <= 1'b1;
      state_q <= IDLE;
      timer_q <= '0;
    end else if (bus.W_R || !bus.en) begin
      chg_q   <= 1'b0;
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      chg_q   <= (cnt_d != cnt_q);
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.sel = sel_q;
  assign bus.chg = chg_q;
  assign state_o = state_q;
endmodule
